uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 The block SHALL take parameter P_SOF, default 8'hA5, start-of-frame byte.
REQ-002 The block SHALL take parameter P_MAX_LEN, default 16, maximum payload length in bytes (1..16).
REQ-003 The block SHALL take parameter P_TIMEOUT_CNT, default 16'd43400, inter-byte timeout in clk cycles.
REQ-004 clk  input  1  system clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rx_data  input  8  received byte from the UART receiver, valid when rx_done=1.
REQ-007 rx_done  input  1  one-cycle pulse, one byte received.
REQ-008 rx_err  input  1  receiver line error (level, may stay high several cycles).
REQ-009 m_data  output  8  payload byte of a validated frame.
REQ-010 m_valid  output  1  m_data valid.
REQ-011 m_last  output  1  m_data is the final payload byte (qualified by m_valid).
REQ-012 m_ready  input  1  downstream accepts m_data; a transfer is m_valid&&m_ready.
REQ-013 frame_ok  output  1  one-cycle pulse, frame checksum matched.
REQ-014 frame_err  output  1  one-cycle pulse, frame discarded.
REQ-015 err_code  output  3  cause, valid with frame_err: 0 line, 1 length, 2 checksum, 3 timeout, 4 overrun.

Function
REQ-016 Frame format SHALL be SOF, LEN, LEN payload bytes, CHK; CHK = XOR of LEN and all payload bytes.
REQ-017 FSM states SHALL be IDLE, LEN, PAYLOAD, CHK, OUT.
REQ-018 IDLE: rx_done with rx_data==P_SOF -> LEN; any other byte ignored, no error.
REQ-019 LEN: rx_done with rx_data==0 or >P_MAX_LEN -> frame_err code 1, IDLE; else store LEN, seed checksum with LEN, write index 0 -> PAYLOAD.
REQ-020 PAYLOAD: each rx_done writes rx_data to buffer[index], XORs into checksum, increments index; after byte index LEN-1 -> CHK.
REQ-021 CHK: rx_done with rx_data==checksum -> frame_ok pulse, OUT; mismatch -> frame_err code 2, IDLE.
REQ-022 OUT: buffer bytes 0..LEN-1 presented in order; m_valid first asserted exactly 2 cycles after the CHK rx_done; m_data/m_valid/m_last held stable while m_ready=0.
REQ-023 OUT: a transfer with m_last=1 -> IDLE; m_valid drops the following cycle; back-to-back transfers at one byte per cycle when m_ready held high.
REQ-024 rx_done in OUT SHALL drop the byte and pulse frame_err code 4; output stream unaffected.
REQ-025 Rising edge of rx_err in LEN, PAYLOAD or CHK SHALL pulse frame_err code 0 and return to IDLE; rx_err ignored in IDLE and OUT.
REQ-026 Rising edge of rx_err coincident with rx_done SHALL take priority; that byte is discarded.
REQ-027 Timeout counter SHALL clear on every rx_done and in IDLE/OUT, count otherwise; reaching P_TIMEOUT_CNT in LEN/PAYLOAD/CHK -> frame_err code 3, IDLE.
REQ-028 rx_done in the cycle the counter reaches P_TIMEOUT_CNT SHALL win; no timeout.
REQ-029 frame_ok and frame_err SHALL never assert in the same cycle; a discarded frame SHALL produce no m_valid.
REQ-030 Checksum and index arithmetic SHALL be 8-bit XOR and 5-bit unsigned respectively, no wrap past P_MAX_LEN.

Reset
REQ-031 On rst=0 the FSM SHALL enter IDLE asynchronously; m_data=0, m_valid=0, m_last=0, frame_ok=0, frame_err=0, err_code=0, counters, index and checksum 0.
REQ-032 Reset mid-frame or mid-OUT SHALL discard the frame; buffer contents need not be cleared.
REQ-033 The first frame after reset release SHALL be parsed normally from IDLE.

Structure
REQ-034 P_SOF, P_MAX_LEN, P_TIMEOUT_CNT, state encodings and err_code values SHALL live in a shared UART package.
REQ-035 Payload storage SHALL be a sub-module uart_frame_buf: 16x8, one write port, one synchronous read port, no reset on storage.

Verification
REQ-036 A5 03 11 22 33 03 with m_ready=1 -> frame_ok once; m_data 11,22,33; m_last on 33; no frame_err.
REQ-037 Same frame, CHK=04 -> frame_err code 2; no m_valid.
REQ-038 A5 00, and A5 11 -> frame_err code 1 each; parser accepts a following good frame.
REQ-039 A5 02 10, then 43400 idle cycles -> frame_err code 3; next A5 01 7E 7F -> frame_ok, m_data 7E.
REQ-040 Good frame with m_ready toggling 0/1 every cycle, plus extra byte 55 during OUT -> output stable while stalled, all bytes in order, frame_err code 4 once.
REQ-041 rx_err pulse after A5 02 10 -> frame_err code 0; rst=0 mid-OUT -> all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/uart_frame_parser_pkg.sv
// Shared constants, state encoding and error codes for the UART frame parser.
package uart_frame_parser_pkg;

  localparam logic [7:0]  DEF_SOF         = 8'hA5;
  localparam int          DEF_MAX_LEN     = 16;
  localparam logic [15:0] DEF_TIMEOUT_CNT = 16'd43400;

  localparam int BUF_DEPTH = 16;
  localparam int BUF_AW    = 4;
  localparam int IDX_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ERR_LINE     = 3'd0,
    ERR_LENGTH   = 3'd1,
    ERR_CHECKSUM = 3'd2,
    ERR_TIMEOUT  = 3'd3,
    ERR_OVERRUN  = 3'd4
  } err_code_t;

endpackage

// File: rtl/uart_frame_parser_buf.sv
// Payload store: simple dual-port RAM, one write port, registered read port.
module uart_frame_buf
  import uart_frame_parser_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [BUF_AW-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [BUF_AW-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [BUF_DEPTH];

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload/CHK frames from a UART byte stream and replays
// validated payloads on a valid/ready output stream.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter logic [7:0]  P_SOF         = DEF_SOF,
  parameter int          P_MAX_LEN     = DEF_MAX_LEN,
  parameter logic [15:0] P_TIMEOUT_CNT = DEF_TIMEOUT_CNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_err,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code
);

  localparam logic [7:0] MAX_LEN_B = 8'(P_MAX_LEN);

  state_t           state_reg, state_next;
  logic             rx_err_q_reg;
  logic [IDX_W-1:0] len_reg, idx_reg, rd_idx_reg;
  logic [7:0]       chk_reg;
  logic [15:0]      timer_reg;
  logic             m_valid_reg, m_last_reg, frame_ok_reg, frame_err_reg;
  err_code_t        err_code_reg;

  logic             frame_ok_next, frame_err_next, buf_wr_en;
  err_code_t        err_code_next;
  logic             err_rise, in_frame, timeout_hit, len_bad, chk_match, last_wr;
  logic             xfer, rd_load;
  logic [7:0]       buf_rd_data;

  assign err_rise    = rx_err && !rx_err_q_reg;
  assign in_frame    = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) || (state_reg == ST_CHK);
  assign timeout_hit = in_frame && !rx_done && (timer_reg == P_TIMEOUT_CNT - 16'd1);
  assign len_bad     = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
  assign chk_match   = (rx_data == chk_reg);
  assign last_wr     = (idx_reg == len_reg - IDX_W'(1));
  assign xfer        = m_valid_reg && m_ready;
  // Prefetch the next byte whenever the output register is empty or being drained.
  assign rd_load     = (state_reg == ST_OUT) && (rd_idx_reg < len_reg) && (!m_valid_reg || m_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rx_done && rx_data == P_SOF) state_next = ST_LEN;
      end
      ST_LEN: begin
        if (err_rise)         state_next = ST_IDLE;
        else if (rx_done)     state_next = len_bad ? ST_IDLE : ST_PAYLOAD;
        else if (timeout_hit) state_next = ST_IDLE;
      end
      ST_PAYLOAD: begin
        if (err_rise)                state_next = ST_IDLE;
        else if (rx_done && last_wr) state_next = ST_CHK;
        else if (timeout_hit)        state_next = ST_IDLE;
      end
      ST_CHK: begin
        if (err_rise)         state_next = ST_IDLE;
        else if (rx_done)     state_next = chk_match ? ST_OUT : ST_IDLE;
        else if (timeout_hit) state_next = ST_IDLE;
      end
      ST_OUT: begin
        if (xfer && m_last_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_ok_next  = 1'b0;
    frame_err_next = 1'b0;
    err_code_next  = ERR_LINE;
    buf_wr_en      = 1'b0;
    if (in_frame) begin
      if (err_rise) begin
        frame_err_next = 1'b1;
        err_code_next  = ERR_LINE;
      end else if (rx_done) begin
        case (state_reg)
          ST_LEN: begin
            frame_err_next = len_bad;
            err_code_next  = ERR_LENGTH;
          end
          ST_PAYLOAD: buf_wr_en = 1'b1;
          default: begin
            frame_ok_next  = chk_match;
            frame_err_next = !chk_match;
            err_code_next  = ERR_CHECKSUM;
          end
        endcase
      end else if (timeout_hit) begin
        frame_err_next = 1'b1;
        err_code_next  = ERR_TIMEOUT;
      end
    end else if (state_reg == ST_OUT && rx_done) begin
      frame_err_next = 1'b1;
      err_code_next  = ERR_OVERRUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_err_q_reg  <= 1'b0;
      frame_ok_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      err_code_reg  <= ERR_LINE;
      timer_reg     <= '0;
      len_reg       <= '0;
      idx_reg       <= '0;
      chk_reg       <= '0;
      rd_idx_reg    <= '0;
      m_valid_reg   <= 1'b0;
      m_last_reg    <= 1'b0;
    end else begin
      rx_err_q_reg  <= rx_err;
      frame_ok_reg  <= frame_ok_next;
      frame_err_reg <= frame_err_next;
      if (frame_err_next) err_code_reg <= err_code_next;

      if (rx_done || !in_frame) timer_reg <= '0;
      else                      timer_reg <= timer_reg + 16'd1;

      if (state_reg == ST_LEN && rx_done && !err_rise && !len_bad) begin
        len_reg <= rx_data[IDX_W-1:0];
        chk_reg <= rx_data;
        idx_reg <= '0;
      end else if (buf_wr_en) begin
        chk_reg <= chk_reg ^ rx_data;
        idx_reg <= idx_reg + IDX_W'(1);
      end

      if (state_reg == ST_CHK && frame_ok_next) begin
        rd_idx_reg  <= '0;
        m_valid_reg <= 1'b0;
        m_last_reg  <= 1'b0;
      end else if (rd_load) begin
        rd_idx_reg  <= rd_idx_reg + IDX_W'(1);
        m_valid_reg <= 1'b1;
        m_last_reg  <= (rd_idx_reg == len_reg - IDX_W'(1));
      end else if (xfer) begin
        m_valid_reg <= 1'b0;
        m_last_reg  <= 1'b0;
      end
    end
  end

  uart_frame_buf u_buf (
    .clk    (clk),
    .wr_en  (buf_wr_en),
    .wr_addr(idx_reg[BUF_AW-1:0]),
    .wr_data(rx_data),
    .rd_en  (rd_load),
    .rd_addr(rd_idx_reg[BUF_AW-1:0]),
    .rd_data(buf_rd_data)
  );

  assign m_data    = m_valid_reg ? buf_rd_data : 8'd0;
  assign m_valid   = m_valid_reg;
  assign m_last    = m_last_reg;
  assign frame_ok  = frame_ok_reg;
  assign frame_err = frame_err_reg;
  assign err_code  = err_code_reg;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: stimulus pushes expected events and
// payload bytes, a negedge monitor pops and compares them.
module tb_uart_frame_parser;

  localparam int N_TO = 43400;

  logic       clk, rst;
  logic [7:0] rx_data;
  logic       rx_done, rx_err;
  logic [7:0] m_data;
  logic       m_valid, m_last, m_ready;
  logic       frame_ok, frame_err;
  logic [2:0] err_code;

  uart_frame_parser dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  typedef struct packed {
    logic       ok;
    logic [2:0] code;
  } ev_t;

  ev_t        exp_ev[$];
  logic [8:0] exp_b[$];
  int         lat_q[$];
  logic [7:0] fr_pl[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  logic mon_en = 1'b0;
  int   last_rx_cyc = 0;
  int   err_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_out = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        2: m_ready = ~m_ready;
        default: m_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog act=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: events, output transfers, stall stability and first-valid latency.
  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (frame_ok || frame_err) begin
        ev_t e;
        err_cyc = cyc;
        check("ok_err_exclusive", 32'(frame_ok && frame_err), 0);
        if (exp_ev.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event ok=%0b err=%0b code=%0d required=none", frame_ok, frame_err, err_code);
        end else begin
          e = exp_ev.pop_front();
          $display("event ok=%0b err=%0b code=%0d (exp ok=%0b code=%0d)", frame_ok, frame_err, err_code, e.ok, e.code);
          check("event_kind", 32'(frame_ok), 32'(e.ok));
          if (!e.ok) check("err_code", 32'(err_code), 32'(e.code));
        end
      end
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 1);
        check("stall_hold", 32'({m_last, m_data}), 32'(prev_out));
      end
      if (m_valid && !prev_valid && lat_q.size() > 0) begin
        check("first_valid_lat", 32'(cyc - lat_q.pop_front()), 2);
      end
      if (m_valid && m_ready) begin
        if (exp_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte act=%0h required=none", m_data);
        end else begin
          logic [8:0] b;
          b = exp_b.pop_front();
          $display("xfer data=%02h last=%0b (exp %02h/%0b)", m_data, m_last, b[7:0], b[8]);
          check("m_data", 32'(m_data), 32'(b[7:0]));
          check("m_last", 32'(m_last), 32'(b[8]));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_last, m_data};
      prev_valid = m_valid;
    end else begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    last_rx_cyc = cyc;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic gap(input int gmax);
    idle($urandom_range(0, gmax));
  endtask

  task automatic fill_payload(input int n);
    fr_pl.delete();
    for (int i = 0; i < n; i++) fr_pl.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: expected outcome from the frame rules, then drive the bytes.
  task automatic do_frame(input logic [7:0] len_b, input logic [7:0] chk_xor, input int gmax);
    logic [7:0] chk;
    logic       bad_len;
    int         n;
    bad_len = (len_b == 8'd0) || (len_b > 8'd16);
    n = bad_len ? 0 : int'(len_b);
    chk = len_b;
    for (int i = 0; i < n; i++) chk = chk ^ fr_pl[i];
    if (bad_len) exp_ev.push_back(ev_t'{ok: 1'b0, code: 3'd1});
    else if (chk_xor != 8'd0) exp_ev.push_back(ev_t'{ok: 1'b0, code: 3'd2});
    else begin
      exp_ev.push_back(ev_t'{ok: 1'b1, code: 3'd0});
      for (int i = 0; i < n; i++) exp_b.push_back({i == n - 1, fr_pl[i]});
    end
    send_byte(8'hA5);
    gap(gmax);
    send_byte(len_b);
    if (!bad_len) begin
      for (int i = 0; i < n; i++) begin
        gap(gmax);
        send_byte(fr_pl[i]);
      end
      gap(gmax);
      if (chk_xor == 8'd0) lat_q.push_back(cyc);
      send_byte(chk ^ chk_xor);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_b.size() + exp_ev.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    if ((exp_b.size() + exp_ev.size()) != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_b.size() + exp_ev.size());
      exp_b.delete();
      exp_ev.delete();
      lat_q.delete();
    end
    idle(3);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!m_valid && n < budget) begin
      tick();
      n++;
    end
    if (!m_valid) begin
      total++;
      bad++;
      $display("FAIL wait_valid act=0 required=1");
    end
  endtask

  initial begin
    int t0;
    rst = 1'b0;
    rx_data = 8'd0;
    rx_done = 1'b0;
    rx_err = 1'b0;
    idle(3);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_frame_ok", 32'(frame_ok), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_err_code", 32'(err_code), 0);
    rst = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // A5 03 11 22 33 03, then bad checksum 04
    ready_mode = 0;
    fr_pl.delete();
    fr_pl.push_back(8'h11);
    fr_pl.push_back(8'h22);
    fr_pl.push_back(8'h33);
    do_frame(8'h03, 8'h00, 0);
    drain(200);
    do_frame(8'h03, 8'h07, 0);
    drain(200);

    // Length 0 and 0x11 rejected, then a good frame
    do_frame(8'h00, 8'h00, 0);
    drain(200);
    do_frame(8'h11, 8'h00, 0);
    drain(200);
    fill_payload(5);
    do_frame(8'd5, 8'h00, 1);
    drain(200);

    // Line error mid-payload
    exp_ev.push_back(ev_t'{ok: 1'b0, code: 3'd0});
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h10);
    idle(2);
    rx_err = 1'b1;
    idle(3);
    rx_err = 1'b0;
    drain(200);

    // Line error rising with rx_done: byte discarded
    exp_ev.push_back(ev_t'{ok: 1'b0, code: 3'd0});
    send_byte(8'hA5);
    rx_err = 1'b1;
    send_byte(8'h02);
    idle(2);
    rx_err = 1'b0;
    drain(200);

    // Line error while idle is ignored
    rx_err = 1'b1;
    idle(2);
    rx_err = 1'b0;
    idle(5);

    // Inter-byte timeout, then A5 01 7E 7F
    exp_ev.push_back(ev_t'{ok: 1'b0, code: 3'd3});
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h10);
    t0 = last_rx_cyc;
    drain(N_TO + 100);
    check("timeout_window", 32'((err_cyc - t0 >= N_TO) && (err_cyc - t0 <= N_TO + 2)), 1);
    fr_pl.delete();
    fr_pl.push_back(8'h7E);
    do_frame(8'h01, 8'h00, 0);
    drain(200);

    // Stalled output with an overrun byte during OUT
    ready_mode = 2;
    fill_payload(8);
    do_frame(8'd8, 8'h00, 1);
    wait_valid(100);
    exp_ev.push_back(ev_t'{ok: 1'b0, code: 3'd4});
    send_byte(8'h55);
    drain(500);

    // Randomized frames with garbage, bad lengths and corrupted checksums
    for (int f = 0; f < 30; f++) begin
      logic [7:0] len_b, cx, g;
      ready_mode = $urandom_range(0, 2);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g);
        gap(2);
      end
      if ($urandom_range(0, 9) == 0)
        len_b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(17, 255));
      else
        len_b = 8'($urandom_range(1, 16));
      cx = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      fill_payload(16);
      do_frame(len_b, cx, 3);
      drain(1000);
    end

    // Reset while a byte is presented: outputs clear at once, parser restarts
    ready_mode = 3;
    fill_payload(4);
    do_frame(8'd4, 8'h00, 0);
    wait_valid(100);
    mon_en = 1'b0;
    exp_b.delete();
    exp_ev.delete();
    lat_q.delete();
    #2;
    rst = 1'b0;
    #1;
    check("arst_m_valid", 32'(m_valid), 0);
    check("arst_m_data", 32'(m_data), 0);
    check("arst_m_last", 32'(m_last), 0);
    check("arst_frame_ok", 32'(frame_ok), 0);
    check("arst_frame_err", 32'(frame_err), 0);
    tick();
    rst = 1'b1;
    ready_mode = 0;
    mon_en = 1'b1;
    idle(2);
    fill_payload(6);
    do_frame(8'd6, 8'h00, 1);
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
